torus_grid_io: RTL and testbench

- Parametrised successor to the fixed 25x25 cellular grid. It holds a WIDTH x HEIGHT array of per-cell state registers and one core instance per cell, broadcasting instruction, PC and SP to every core.
- New capabilities: selectable toroidal or fixed-value boundary, host random-access cell writes, a raster-order state dump stream with valid/ready handshake, a registered divergence consensus, and a step counter.
- Sits between the sequencer (instruction and PC/SP broadcast) and the host/video side.

---
 rtl/grid_pkg.sv | 13 +
 rtl/grid_core.sv | 33 +++
 rtl/grid_dump_ctrl.sv | 63 ++++++
 rtl/torus_grid_io.sv | 79 +++++++
 tb/tb_torus_grid_io.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/grid_pkg.sv
// grid_pkg: shared cell, broadcast and dump types for the cellular grid.
package grid_pkg;
  typedef logic [7:0] value_t;
  typedef value_t register_t;
  typedef logic [7:0] pc_t;
  typedef logic [7:0] sp_t;
  typedef enum logic [2:0] {OP_NOP, OP_N, OP_S, OP_W, OP_E, OP_ADD, OP_XY, OP_PCSP} instruction_t;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} dump_state_t;
  localparam register_t DIVERGE_VALUE = 8'hFF;
  function automatic int coord_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/grid_core.sv
// grid_core: per-cell compute core producing next state and divergence flag.
module grid_core
  import grid_pkg::*;
#(
  parameter int X = 0,
  parameter int Y = 0
) (
  input  instruction_t instruction,
  input  pc_t          pc,
  input  sp_t          sp,
  input  register_t    i01,
  input  register_t    i21,
  input  register_t    i10,
  input  register_t    i11,
  input  register_t    i12,
  output register_t    next_state,
  output logic         diverge
);
  always_comb begin
    next_state = i11;
    case (instruction)
      OP_N:    next_state = i01;
      OP_S:    next_state = i21;
      OP_W:    next_state = i10;
      OP_E:    next_state = i12;
      OP_ADD:  next_state = i01 + i21 + i10 + i12;
      OP_XY:   next_state = register_t'(X * 16 + Y);
      OP_PCSP: next_state = pc ^ sp;
      default: next_state = i11;
    endcase
    diverge = i11 != DIVERGE_VALUE;
  end
endmodule

// File: rtl/grid_dump_ctrl.sv
// grid_dump_ctrl: raster dump FSM, beat counters, last/done and host-write gating.
module grid_dump_ctrl
  import grid_pkg::*;
#(
  parameter int WIDTH  = 25,
  parameter int HEIGHT = 25,
  parameter int XW     = coord_w(WIDTH),
  parameter int YW     = coord_w(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          global_enable,
  input  logic          dump_start,
  input  logic          dump_ready,
  output logic          wr_ready,
  output logic          dump_valid,
  output logic [XW-1:0] dump_x,
  output logic [YW-1:0] dump_y,
  output logic          dump_last,
  output logic          dump_done,
  output logic          busy
);
  dump_state_t state, state_n;
  logic [XW-1:0] x_n;
  logic [YW-1:0] y_n;
  logic fire, row_end;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      dump_x <= '0;
      dump_y <= '0;
    end else begin
      state  <= state_n;
      dump_x <= x_n;
      dump_y <= y_n;
    end
  end
  always_comb begin
    dump_valid = state == STREAM && !global_enable;
    fire       = dump_valid && dump_ready;
    row_end    = dump_x == XW'(WIDTH - 1);
    dump_last  = state == STREAM && row_end && dump_y == YW'(HEIGHT - 1);
    state_n    = state;
    x_n        = dump_x;
    y_n        = dump_y;
    case (state)
      IDLE: begin
        state_n = dump_start ? STREAM : IDLE;
        x_n     = dump_start ? '0 : dump_x;
        y_n     = dump_start ? '0 : dump_y;
      end
      STREAM: begin
        state_n = (fire && dump_last) ? DONE : STREAM;
        x_n     = fire ? (row_end ? '0 : dump_x + 1'b1) : dump_x;
        y_n     = (fire && row_end) ? (dump_last ? '0 : dump_y + 1'b1) : dump_y;
      end
      default: state_n = IDLE;
    endcase
  end
  assign dump_done = state == DONE;
  assign busy      = state != IDLE;
  assign wr_ready  = !global_enable && state == IDLE;
endmodule

// File: rtl/torus_grid_io.sv
// torus_grid_io: WIDTH x HEIGHT cell grid with per-cell cores, host writes, raster dump and step count.
module torus_grid_io
  import grid_pkg::*;
#(
  parameter int        WIDTH          = 25,
  parameter int        HEIGHT         = 25,
  parameter bit        WRAP           = 1,
  parameter register_t BOUNDARY_VALUE = '0,
  parameter int        CNT_W          = 32,
  localparam int       XW             = coord_w(WIDTH),
  localparam int       YW             = coord_w(HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  instruction_t     instruction,
  input  pc_t              next_program_counter,
  input  sp_t              next_stack_pointer,
  input  logic             global_enable,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [XW-1:0]    wr_x,
  input  logic [YW-1:0]    wr_y,
  input  register_t        wr_data,
  input  logic             dump_start,
  output logic             dump_valid,
  input  logic             dump_ready,
  output register_t        dump_data,
  output logic [XW-1:0]    dump_x,
  output logic [YW-1:0]    dump_y,
  output logic             dump_last,
  output logic             dump_done,
  output logic             busy,
  output logic             diverge_consensus,
  output logic [CNT_W-1:0] step_count
);
  register_t states [HEIGHT][WIDTH];
  register_t nexts  [HEIGHT][WIDTH];
  logic [HEIGHT*WIDTH-1:0] diverges;
  logic wr_fire;
  assign wr_fire   = wr_valid && wr_ready;
  assign dump_data = states[dump_y][dump_x];
  grid_dump_ctrl #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW)) u_ctrl (
    .clk(clk), .rst(rst), .global_enable(global_enable), .dump_start(dump_start),
    .dump_ready(dump_ready), .wr_ready(wr_ready), .dump_valid(dump_valid),
    .dump_x(dump_x), .dump_y(dump_y), .dump_last(dump_last), .dump_done(dump_done), .busy(busy)
  );
  for (genvar y = 0; y < HEIGHT; y++) begin : g_row
    for (genvar x = 0; x < WIDTH; x++) begin : g_col
      localparam int  YU = (y + HEIGHT - 1) % HEIGHT;
      localparam int  YD = (y + 1) % HEIGHT;
      localparam int  XL = (x + WIDTH - 1) % WIDTH;
      localparam int  XR = (x + 1) % WIDTH;
      // wrapped indices are always legal; edges simply substitute the boundary constant
      localparam bit  EU = !WRAP && y == 0;
      localparam bit  ED = !WRAP && y == HEIGHT - 1;
      localparam bit  EL = !WRAP && x == 0;
      localparam bit  ER = !WRAP && x == WIDTH - 1;
      register_t i01, i21, i10, i12;
      assign i01 = EU ? BOUNDARY_VALUE : states[YU][x];
      assign i21 = ED ? BOUNDARY_VALUE : states[YD][x];
      assign i10 = EL ? BOUNDARY_VALUE : states[y][XL];
      assign i12 = ER ? BOUNDARY_VALUE : states[y][XR];
      grid_core #(.X(x), .Y(y)) u_core (
        .instruction(instruction), .pc(next_program_counter), .sp(next_stack_pointer),
        .i01(i01), .i21(i21), .i10(i10), .i11(states[y][x]), .i12(i12),
        .next_state(nexts[y][x]), .diverge(diverges[y*WIDTH+x])
      );
    end
  end
  always_ff @(posedge clk) begin
    for (int j = 0; j < HEIGHT; j++)
      for (int i = 0; i < WIDTH; i++)
        if (rst) states[j][i] <= '0;
        else if (global_enable) states[j][i] <= nexts[j][i];
        else if (wr_fire && int'(wr_x) == i && int'(wr_y) == j) states[j][i] <= wr_data;
    diverge_consensus <= rst ? 1'b0 : &diverges;
    step_count <= rst ? '0 : step_count + CNT_W'(global_enable);
  end
endmodule

// File: tb/tb_torus_grid_io.sv
// tb_torus_grid_io: directed vectors and hand-written sequences for wrap/boundary grids.
module tb_torus_grid_io;
  import grid_pkg::*;
  logic clk = 0, rst = 1;
  instruction_t instruction = OP_NOP;
  pc_t pc = 8'h5A;
  sp_t sp = 8'h0F;
  logic ge = 0, wr_valid = 0, dump_start = 0, dump_ready = 0;
  logic [1:0] wr_x = 0, wr_y = 0;
  register_t wr_data = 0;
  logic a_wr_ready, a_dump_valid, a_dump_last, a_dump_done, a_busy, a_cons;
  logic b_wr_ready, b_dump_valid, b_dump_last, b_dump_done, b_busy, b_cons;
  register_t a_dump_data, b_dump_data;
  logic [1:0] a_dump_x, a_dump_y, b_dump_x, b_dump_y;
  logic [31:0] a_step;
  logic [2:0] b_step;
  int total = 0, bad = 0;
  register_t ga [3][4];
  register_t gb [3][4];

  always #5 clk = ~clk;

  torus_grid_io #(.WIDTH(4), .HEIGHT(3), .WRAP(1)) dut_a (
    .clk(clk), .rst(rst), .instruction(instruction), .next_program_counter(pc),
    .next_stack_pointer(sp), .global_enable(ge), .wr_valid(wr_valid), .wr_ready(a_wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .dump_start(dump_start),
    .dump_valid(a_dump_valid), .dump_ready(dump_ready), .dump_data(a_dump_data),
    .dump_x(a_dump_x), .dump_y(a_dump_y), .dump_last(a_dump_last), .dump_done(a_dump_done),
    .busy(a_busy), .diverge_consensus(a_cons), .step_count(a_step)
  );
  torus_grid_io #(.WIDTH(4), .HEIGHT(3), .WRAP(0), .BOUNDARY_VALUE(8'd9), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .instruction(instruction), .next_program_counter(pc),
    .next_stack_pointer(sp), .global_enable(ge), .wr_valid(wr_valid), .wr_ready(b_wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .dump_start(dump_start),
    .dump_valid(b_dump_valid), .dump_ready(dump_ready), .dump_data(b_dump_data),
    .dump_x(b_dump_x), .dump_y(b_dump_y), .dump_last(b_dump_last), .dump_done(b_dump_done),
    .busy(b_busy), .diverge_consensus(b_cons), .step_count(b_step)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    #1;
  endtask
  task automatic do_reset;
    rst = 1; ge = 0; wr_valid = 0; dump_start = 0; dump_ready = 0; instruction = OP_NOP;
    tick;
    tick;
    rst = 0;
  endtask
  task automatic write_cell(input int x, input int y, input register_t d);
    wr_valid = 1; wr_x = 2'(x); wr_y = 2'(y); wr_data = d;
    settle;
    chk("wr_ready_idle", a_wr_ready, 1);
    tick;
    wr_valid = 0;
  endtask
  task automatic dump_all;
    int beats;
    beats = 0;
    dump_start = 1;
    tick;
    dump_start = 0; dump_ready = 1;
    for (int c = 0; c < 40 && beats < 12; c++) begin
      settle;
      if (a_dump_valid) begin
        ga[a_dump_y][a_dump_x] = a_dump_data;
        gb[b_dump_y][b_dump_x] = b_dump_data;
        beats++;
      end
      tick;
    end
    chk("dump_all_beats", beats, 12);
    dump_ready = 0;
    tick;
  endtask

  typedef struct {
    instruction_t op;
    int cx, cy;
    register_t ea, eb;
  } vec_t;
  vec_t v [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int beats, c;
    logic done, ge_done, saw_done;
    int nz;
    v[0]  = '{OP_E,    3, 0, 8'd7,  8'd9};
    v[1]  = '{OP_W,    0, 2, 8'd5,  8'd9};
    v[2]  = '{OP_N,    0, 1, 8'd7,  8'd7};
    v[3]  = '{OP_N,    0, 0, 8'd0,  8'd9};
    v[4]  = '{OP_S,    2, 0, 8'd4,  8'd4};
    v[5]  = '{OP_ADD,  1, 1, 8'd7,  8'd7};
    v[6]  = '{OP_ADD,  0, 0, 8'd3,  8'd21};
    v[7]  = '{OP_ADD,  3, 2, 8'd0,  8'd18};
    v[8]  = '{OP_XY,   2, 1, 8'd33, 8'd33};
    v[9]  = '{OP_PCSP, 1, 2, 8'h55, 8'h55};
    v[10] = '{OP_NOP,  0, 0, 8'd7,  8'd7};
    v[11] = '{OP_S,    3, 2, 8'd0,  8'd9};

    rst = 1;
    tick;
    tick;
    settle;
    chk("rst_step_a", a_step, 0);
    chk("rst_step_b", b_step, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_valid", a_dump_valid, 0);
    chk("rst_done", a_dump_done, 0);
    chk("rst_cons", a_cons, 0);
    chk("rst_wr_ready", a_wr_ready, 1);
    rst = 0;

    // neighbour vectors: fixed seed cells, one enabled step, read back by dump
    foreach (v[k]) begin
      do_reset;
      write_cell(0, 0, 8'd7);
      write_cell(1, 0, 8'd3);
      write_cell(2, 1, 8'd4);
      write_cell(3, 2, 8'd5);
      instruction = v[k].op; ge = 1;
      tick;
      ge = 0;
      dump_all;
      chk($sformatf("vec%0d_wrap", k), ga[v[k].cy][v[k].cx], v[k].ea);
      chk($sformatf("vec%0d_bound", k), gb[v[k].cy][v[k].cx], v[k].eb);
    end

    // full raster dump, plus a rejected write while busy
    do_reset;
    for (int k = 0; k < 12; k++) write_cell(k % 4, k / 4, register_t'(k));
    dump_start = 1;
    tick;
    dump_start = 0; dump_ready = 1; beats = 0; done = 0;
    for (c = 0; c < 40 && !done; c++) begin
      wr_valid = (c == 3); wr_x = 3; wr_y = 2; wr_data = 8'hAA;
      settle;
      if (wr_valid) chk("wr_ready_busy", a_wr_ready, 0);
      if (a_dump_valid) begin
        chk($sformatf("raster_data%0d", beats), a_dump_data, beats);
        chk($sformatf("raster_last%0d", beats), a_dump_last, beats == 11);
        if (a_dump_last) done = 1;
        beats++;
      end
      tick;
    end
    wr_valid = 0; dump_ready = 0;
    chk("raster_beats", beats, 12);
    settle;
    chk("raster_done", a_dump_done, 1);
    chk("raster_busy_done", a_busy, 1);
    tick;
    chk("raster_done_pulse", a_dump_done, 0);
    chk("raster_busy_fall", a_busy, 0);

    // stalled stream with toggling ready and one enable step at beat 4
    do_reset;
    for (int k = 0; k < 12; k++) write_cell(k % 4, k / 4, register_t'(k));
    instruction = OP_PCSP;
    dump_start = 1;
    tick;
    dump_start = 0; beats = 0; done = 0; ge_done = 0;
    for (c = 0; c < 60 && !done; c++) begin
      ge = beats == 4 && !ge_done;
      dump_ready = (c % 3) != 1;
      settle;
      if (ge) begin
        chk("stall_valid", a_dump_valid, 0);
        chk("stall_wr_ready", a_wr_ready, 0);
        ge_done = 1;
      end
      if (a_dump_valid && dump_ready) begin
        chk($sformatf("stall_x%0d", beats), a_dump_x, beats % 4);
        chk($sformatf("stall_y%0d", beats), a_dump_y, beats / 4);
        chk($sformatf("stall_data%0d", beats), a_dump_data, beats < 4 ? beats : 8'h55);
        if (a_dump_last) done = 1;
        beats++;
      end
      tick;
    end
    ge = 0; dump_ready = 0;
    chk("stall_beats", beats, 12);
    chk("stall_step", a_step, 1);
    settle;
    chk("stall_done", a_dump_done, 1);
    tick;

    // reset in the middle of a dump
    do_reset;
    write_cell(1, 1, 8'h22);
    dump_start = 1;
    tick;
    dump_start = 0; dump_ready = 1; beats = 0;
    for (c = 0; c < 20 && beats < 6; c++) begin
      settle;
      if (a_dump_valid) beats++;
      tick;
    end
    chk("abort_beats", beats, 6);
    rst = 1;
    tick;
    rst = 0; dump_ready = 0;
    settle;
    chk("abort_busy", a_busy, 0);
    chk("abort_valid", a_dump_valid, 0);
    saw_done = 0;
    for (int k = 0; k < 5; k++) begin
      saw_done |= a_dump_done;
      tick;
    end
    chk("abort_no_done", saw_done, 0);
    write_cell(1, 3, 8'h44);
    ge = 1; instruction = OP_NOP; wr_valid = 1; wr_x = 1; wr_y = 1; wr_data = 8'h33;
    settle;
    chk("ge_wr_ready", a_wr_ready, 0);
    tick;
    ge = 0; wr_valid = 0;
    dump_all;
    nz = 0;
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 4; i++) nz += (ga[j][i] != 0) + (gb[j][i] != 0);
    chk("cleared_cells", nz, 0);

    // divergence consensus latency and step counter wrap
    do_reset;
    settle;
    chk("cons_reset", a_cons, 0);
    tick;
    chk("cons_rise", a_cons, 1);
    write_cell(2, 2, 8'hFF);
    chk("cons_lag", a_cons, 1);
    tick;
    chk("cons_fall", a_cons, 0);
    write_cell(2, 2, 8'h00);
    chk("cons_lag0", a_cons, 0);
    tick;
    chk("cons_back", a_cons, 1);
    instruction = OP_NOP; ge = 1;
    repeat (9) tick;
    ge = 0;
    chk("step_a", a_step, 9);
    chk("step_b_wrap", b_step, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
